// File: rtl/decim_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decim_pkg - shared types and oversampling-ratio clamp for decim_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
package decim_pkg;

  localparam int CNT_W_DEFAULT = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  // Largest usable log2 window: the all-ones count 2^eff must still fit CNT_W bits.
  function automatic logic [3:0] osr_limit(input int cnt_w);
    return 4'(cnt_w - 1);
  endfunction

  function automatic logic [3:0] clamp_osr(input logic [3:0] osr, input logic [3:0] lim);
    if (osr == 4'd0) return 4'd1;
    if (osr > lim)   return lim;
    return osr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decim_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decim_fifo - synchronous first-word-fall-through FIFO, head word is 0 when empty
// Rev 1.0
// ---------------------------------------------------------------------------
module decim_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/decim_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decim_ctrl - sigma-delta window counter with settle sequencing and result FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
module decim_ctrl
  import decim_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [3:0]        osr_log2,
  input  logic [3:0]        settle,
  input  logic              stream_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam logic [3:0] OSR_LIM = osr_limit(CNT_W);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       eff;
  logic [3:0]       settle_cnt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] win_last;
  logic [CNT_W-1:0] result;
  logic             win_end;
  logic             push;
  logic             drop;
  logic             full;
  logic             empty;

  assign win_last = (CNT_W'(1) << eff) - CNT_W'(1);
  assign win_end  = (cnt == win_last);
  assign result   = acc + CNT_W'(stream_in);
  assign busy     = (state != ST_IDLE);
  assign out_valid = !empty;
  // Full implies non-empty, so out_ready alone decides whether a slot frees up.
  assign drop     = push && full && !out_ready;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) state_nxt = (settle != 4'd0) ? ST_SETTLE : ST_RUN;
      end
      ST_SETTLE: begin
        if (!en)                                    state_nxt = ST_IDLE;
        else if (win_end && (settle_cnt == 4'd1))   state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!en)          state_nxt = ST_IDLE;
        else if (win_end) push = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      eff        <= 4'd1;
      settle_cnt <= 4'd0;
      cnt        <= '0;
      acc        <= '0;
      ovf        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && en) begin
        eff        <= clamp_osr(osr_log2, OSR_LIM);
        settle_cnt <= settle;
      end
      // Idle or an aborted run discards the partial window.
      if (state == ST_IDLE || !en) begin
        cnt <= '0;
        acc <= '0;
      end else if (win_end) begin
        cnt <= '0;
        acc <= '0;
        if (state == ST_SETTLE) settle_cnt <= settle_cnt - 4'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
        acc <= result;
      end
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  decim_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (out_ready),
    .wdata (DATA_W'(result)),
    .rdata (out_data),
    .full  (full),
    .empty (empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_decim_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_decim_ctrl - directed checkpoint table plus randomized run against a window/queue model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_decim_ctrl;

  localparam int CNT_W  = 12;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [3:0]        osr_log2;
  logic [3:0]        settle;
  logic              stream_in;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              ovf;
  logic              ovf_clr;

  decim_ctrl #(
    .CNT_W      (CNT_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .osr_log2  (osr_log2),
    .settle    (settle),
    .stream_in (stream_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cur         = 0;
  int pattern     = 0;

  // Checkpoint record: expected outputs at cycle cyc, then inputs driven from that cycle on.
  typedef struct {
    int cyc;
    int ev;
    int ed;
    int eb;
    int eo;
    int en;
    int osr;
    int rdy;
    int clr;
    int rst;
  } chk_t;

  chk_t tbl[$];

  // Reference model: window position / ones count / queue of results.
  int m_mode;   // 0 idle, 1 settling, 2 running
  int m_pos;
  int m_ones;
  int m_win;
  int m_left;
  int m_ovf;
  int q[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cur, act, exp);
    end
  endtask

  function automatic int clamp_eff(input int o);
    if (o < 1) return 1;
    if (o > CNT_W - 1) return CNT_W - 1;
    return o;
  endfunction

  task automatic model_check();
    check("model_valid", int'(out_valid), (q.size() > 0) ? 1 : 0);
    check("model_data", int'(out_data), (q.size() > 0) ? q[0] : 0);
    check("model_busy", int'(busy), (m_mode != 0) ? 1 : 0);
    check("model_ovf", int'(ovf), m_ovf);
  endtask

  task automatic model_step();
    bit do_pop;
    bit have;
    bit drop;
    int res;
    do_pop = (q.size() > 0) && out_ready;
    have   = 0;
    drop   = 0;
    res    = 0;
    if (!rst_n) begin
      m_mode = 0; m_pos = 0; m_ones = 0; m_ovf = 0;
      q.delete();
    end else begin
      if (m_mode == 0) begin
        if (en) begin
          m_win  = 1 << clamp_eff(int'(osr_log2));
          m_left = int'(settle);
          m_mode = (settle != 0) ? 1 : 2;
          m_pos  = 0;
          m_ones = 0;
        end
      end else if (!en) begin
        m_mode = 0; m_pos = 0; m_ones = 0;
      end else begin
        m_ones += int'(stream_in);
        m_pos++;
        if (m_pos == m_win) begin
          if (m_mode == 2) begin
            have = 1;
            res  = m_ones;
          end else begin
            m_left--;
            if (m_left == 0) m_mode = 2;
          end
          m_pos  = 0;
          m_ones = 0;
        end
      end
      if (do_pop) void'(q.pop_front());
      if (have) begin
        if (q.size() < DEPTH) q.push_back(res);
        else drop = 1;
      end
      if (drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
    end
  endtask

  task automatic cycle();
    case (pattern)
      0: stream_in = 1'b1;
      1: stream_in = (cur % 2 == 0);
      2: stream_in = (cur % 2 == 1);
      default: stream_in = 1'($urandom_range(0, 1));
    endcase
    model_check();
    @(posedge clk);
    model_step();
    #1;
    cur++;
  endtask

  task automatic scen_begin(input int pat, input int st);
    rst_n = 1'b0; en = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    settle  = 4'(st);
    pattern = pat;
    cur     = 0;
  endtask

  task automatic add(input int cyc, input int ev, input int ed, input int eb, input int eo,
                     input int en_i, input int osr, input int rdy, input int clr, input int rst);
    chk_t c;
    c.cyc = cyc; c.ev = ev; c.ed = ed; c.eb = eb; c.eo = eo;
    c.en = en_i; c.osr = osr; c.rdy = rdy; c.clr = clr; c.rst = rst;
    tbl.push_back(c);
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      while (cur < tbl[i].cyc) cycle();
      check("tbl_valid", int'(out_valid), tbl[i].ev);
      check("tbl_data", int'(out_data), tbl[i].ed);
      check("tbl_busy", int'(busy), tbl[i].eb);
      check("tbl_ovf", int'(ovf), tbl[i].eo);
      en        = 1'(tbl[i].en);
      osr_log2  = 4'(tbl[i].osr);
      out_ready = 1'(tbl[i].rdy);
      ovf_clr   = 1'(tbl[i].clr);
      rst_n     = 1'(tbl[i].rst);
    end
    cycle();
    tbl.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; osr_log2 = 4'd0; settle = 4'd0;
    stream_in = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    m_mode = 0; m_pos = 0; m_ones = 0; m_win = 2; m_left = 0; m_ovf = 0;
    #1;

    // All ones, window 8: first word at cycle 9, then every 8 cycles.
    scen_begin(0, 0);
    add(0, 0, 0, 0, 0, 1, 3, 1, 0, 1);
    add(1, 0, 0, 1, 0, 1, 3, 1, 0, 1);
    add(8, 0, 0, 1, 0, 1, 3, 1, 0, 1);
    add(9, 1, 8, 1, 0, 1, 3, 1, 0, 1);
    add(10, 0, 0, 1, 0, 1, 3, 1, 0, 1);
    add(17, 1, 8, 1, 0, 1, 3, 1, 0, 1);
    run_table();

    // Alternating stream, window 16, both phases give 8.
    scen_begin(1, 0);
    add(0, 0, 0, 0, 0, 1, 4, 1, 0, 1);
    add(16, 0, 0, 1, 0, 1, 4, 1, 0, 1);
    add(17, 1, 8, 1, 0, 1, 4, 1, 0, 1);
    add(33, 1, 8, 1, 0, 1, 4, 1, 0, 1);
    run_table();
    scen_begin(2, 0);
    add(0, 0, 0, 0, 0, 1, 4, 1, 0, 1);
    add(17, 1, 8, 1, 0, 1, 4, 1, 0, 1);
    run_table();

    // Two settle windows discarded, third window delivers 4 at cycle 13.
    scen_begin(0, 2);
    add(0, 0, 0, 0, 0, 1, 2, 1, 0, 1);
    add(1, 0, 0, 1, 0, 1, 2, 1, 0, 1);
    add(8, 0, 0, 1, 0, 1, 2, 1, 0, 1);
    add(12, 0, 0, 1, 0, 1, 2, 1, 0, 1);
    add(13, 1, 4, 1, 0, 1, 2, 1, 0, 1);
    run_table();

    // Fill with no consumer, overflow on 5th result, drain, clear.
    scen_begin(0, 0);
    add(0, 0, 0, 0, 0, 1, 2, 0, 0, 1);
    add(5, 1, 4, 1, 0, 1, 2, 0, 0, 1);
    add(16, 1, 4, 1, 0, 1, 2, 0, 0, 1);
    add(17, 1, 4, 1, 0, 1, 2, 0, 0, 1);
    add(20, 1, 4, 1, 0, 1, 2, 0, 0, 1);
    add(21, 1, 4, 1, 1, 0, 2, 1, 0, 1);
    add(22, 1, 4, 0, 1, 0, 2, 1, 0, 1);
    add(24, 1, 4, 0, 1, 0, 2, 1, 0, 1);
    add(25, 0, 0, 0, 1, 0, 2, 1, 1, 1);
    add(26, 0, 0, 0, 0, 0, 2, 1, 0, 1);
    run_table();

    // Abort 3 cycles into a window, osr change while busy ignored, restart with osr 2.
    scen_begin(0, 0);
    add(0, 0, 0, 0, 0, 1, 3, 1, 0, 1);
    add(3, 0, 0, 1, 0, 1, 5, 1, 0, 1);
    add(9, 1, 8, 1, 0, 1, 5, 1, 0, 1);
    add(10, 0, 0, 1, 0, 1, 5, 1, 0, 1);
    add(12, 0, 0, 1, 0, 0, 2, 1, 0, 1);
    add(13, 0, 0, 0, 0, 1, 2, 1, 0, 1);
    add(14, 0, 0, 1, 0, 1, 2, 1, 0, 1);
    add(17, 0, 0, 1, 0, 1, 2, 1, 0, 1);
    add(18, 1, 4, 1, 0, 1, 2, 1, 0, 1);
    run_table();

    // osr 0 clamps to a 2-cycle window.
    scen_begin(0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
    add(2, 0, 0, 1, 0, 1, 0, 1, 0, 1);
    add(3, 1, 2, 1, 0, 1, 0, 1, 0, 1);
    add(4, 0, 0, 1, 0, 1, 0, 1, 0, 1);
    add(5, 1, 2, 1, 0, 1, 0, 1, 0, 1);
    run_table();

    // osr 15 clamps to 2^11.
    scen_begin(0, 0);
    add(0, 0, 0, 0, 0, 1, 15, 1, 0, 1);
    add(2048, 0, 0, 1, 0, 1, 15, 1, 0, 1);
    add(2049, 1, 2048, 1, 0, 1, 15, 1, 0, 1);
    run_table();

    // Reset mid-window with a full FIFO and ovf set.
    scen_begin(0, 0);
    add(0, 0, 0, 0, 0, 1, 2, 0, 0, 1);
    add(21, 1, 4, 1, 1, 1, 2, 0, 0, 1);
    add(22, 1, 4, 1, 1, 1, 2, 0, 0, 0);
    add(23, 0, 0, 0, 0, 1, 2, 0, 0, 1);
    run_table();

    // Randomized run against the model.
    scen_begin(3, 0);
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) en = ~en;
      osr_log2  = ($urandom_range(0, 19) == 0) ? 4'(15 - $urandom_range(0, 3)) : 4'($urandom_range(0, 5));
      settle    = 4'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 99) < 40);
      ovf_clr   = ($urandom_range(0, 99) < 5);
      rst_n     = ($urandom_range(0, 999) >= 3);
      cycle();
    end
    rst_n = 1'b1;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
